// File: rtl/demux12_stream.sv
// demux12_stream: packet-atomic 1-to-2 stream demultiplexer with per-port register slices
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready     input stream handshake
//   s_data/s_last       input beat payload and end-of-packet flag
//   s_sel               destination of a new packet (0 = A, 1 = B), sampled on its first beat
//   a_valid/a_ready     port A handshake
//   a_data/a_last       port A payload
//   b_valid/b_ready     port B handshake
//   b_data/b_last       port B payload
//   busy                a multi-beat packet is mid-transfer
//   cnt_a/cnt_b         packets completed into each port slice (wrapping)
module demux12_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             s_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic             r_sel_q, w_sel_nxt;
    logic             w_route, w_free_a, w_free_b, w_acc, w_load_a, w_load_b;
    logic             r_a_valid, r_b_valid, r_a_last, r_b_last;
    logic [WIDTH-1:0] r_a_data, r_b_data;
    logic [CNT_W-1:0] r_cnt_a, r_cnt_b;

    // Inside a packet the latched destination wins; s_sel only matters on a first beat.
    assign w_route  = (r_state == LOCK) ? r_sel_q : s_sel;
    assign w_free_a = !r_a_valid || a_ready;
    assign w_free_b = !r_b_valid || b_ready;
    assign s_ready  = w_route ? w_free_b : w_free_a;
    assign w_acc    = s_valid && s_ready;
    assign w_load_a = w_acc && !w_route;
    assign w_load_b = w_acc && w_route;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_q;
        if (w_acc && r_state == IDLE && !s_last) begin
            w_state_nxt = LOCK;
            w_sel_nxt   = s_sel;
        end else if (w_acc && r_state == LOCK && s_last) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel_q <= w_sel_nxt;
        end
    end

    // A load in the same cycle as a drain replaces the beat, keeping one beat per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_a_last  <= 1'b0;
        end else if (w_load_a) begin
            r_a_valid <= 1'b1;
            r_a_data  <= s_data;
            r_a_last  <= s_last;
        end else if (a_ready) begin
            r_a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_last  <= 1'b0;
        end else if (w_load_b) begin
            r_b_valid <= 1'b1;
            r_b_data  <= s_data;
            r_b_last  <= s_last;
        end else if (b_ready) begin
            r_b_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_load_a && s_last) r_cnt_a <= r_cnt_a + CNT_ONE;
            if (w_load_b && s_last) r_cnt_b <= r_cnt_b + CNT_ONE;
        end
    end

    assign a_valid = r_a_valid;
    assign a_data  = r_a_data;
    assign a_last  = r_a_last;
    assign b_valid = r_b_valid;
    assign b_data  = r_b_data;
    assign b_last  = r_b_last;
    assign busy    = (r_state == LOCK);
    assign cnt_a   = r_cnt_a;
    assign cnt_b   = r_cnt_b;
endmodule

// File: tb/tb_demux12_stream.sv
// tb_demux12_stream: directed scoreboard bench for demux12_stream (CNT_W = 2 to exercise wrap)
module tb_demux12_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_ready, s_last, s_sel;
    logic [7:0] s_data;
    logic       a_valid, a_ready, a_last;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_last;
    logic [7:0] b_data;
    logic       busy;
    logic [1:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;
    int waits;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic       m_lock, m_sel;
    logic [1:0] m_cnt_a, m_cnt_b;

    demux12_stream #(.WIDTH(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
        .busy(busy), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        m_lock  = 1'b0;
        m_sel   = 1'b0;
        m_cnt_a = '0;
        m_cnt_b = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Presents one beat starting at posedge+1 and returns at posedge+1 after it is accepted.
    task automatic send(input logic [7:0] d, input logic l, input logic s);
        logic r;
        logic done;
        done    = 1'b0;
        waits   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_sel   = s;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                r = m_lock ? m_sel : s;
                if (r) qb.push_back({l, d}); else qa.push_back({l, d});
                if (l && r) m_cnt_b = m_cnt_b + 2'd1;
                if (l && !r) m_cnt_a = m_cnt_a + 2'd1;
                if (!m_lock && !l) begin
                    m_lock = 1'b1;
                    m_sel  = s;
                end else if (m_lock && l) begin
                    m_lock = 1'b0;
                end
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && a_ready) begin
                if (qa.size() == 0) chk("a_extra", {31'd0, a_valid}, 32'd0);
                else chk("a_beat", {23'd0, a_last, a_data}, {23'd0, qa.pop_front()});
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) chk("b_extra", {31'd0, b_valid}, 32'd0);
                else chk("b_beat", {23'd0, b_last, b_data}, {23'd0, qb.pop_front()});
            end
        end
    end

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_sel   = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        do_reset();

        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_s_ready", s_ready, 1);

        send(8'h11, 1'b1, 1'b0);
        chk("single_a_valid", a_valid, 1);
        chk("single_a_data", a_data, 8'h11);
        chk("single_busy0", busy, 0);
        send(8'h22, 1'b1, 1'b1);
        chk("single_b_valid", b_valid, 1);
        chk("single_b_data", b_data, 8'h22);
        chk("single_busy1", busy, 0);
        chk("single_cnt_a", cnt_a, 1);
        chk("single_cnt_b", cnt_b, 1);

        send(8'hA0, 1'b0, 1'b1);
        chk("lock_busy0", busy, 1);
        send(8'hA1, 1'b0, 1'b0);
        chk("lock_busy1", busy, 1);
        send(8'hA2, 1'b0, 1'b0);
        chk("lock_busy2", busy, 1);
        send(8'hA3, 1'b1, 1'b0);
        chk("lock_busy3", busy, 0);
        chk("lock_b_data", b_data, 8'hA3);
        chk("lock_b_last", b_last, 1);
        chk("lock_cnt_b", cnt_b, m_cnt_b);
        chk("lock_cnt_a", cnt_a, m_cnt_a);

        a_ready = 1'b0;
        send(8'h31, 1'b1, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h32;
        s_last  = 1'b1;
        s_sel   = 1'b0;
        @(negedge clk);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_a_valid", a_valid, 1);
        chk("bp_a_data", a_data, 8'h31);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_hold_data", a_data, 8'h31);
        chk("bp_hold_ready", s_ready, 0);
        @(posedge clk);
        #1;
        send(8'h40, 1'b1, 1'b1);
        chk("bp_b_waits", waits, 0);
        chk("bp_b_data", b_data, 8'h40);
        chk("bp_a_still", a_data, 8'h31);
        a_ready = 1'b1;
        send(8'h32, 1'b1, 1'b0);
        chk("bp_drain_w0", waits, 0);
        send(8'h33, 1'b1, 1'b0);
        chk("bp_drain_w1", waits, 0);
        chk("bp_drain_data", a_data, 8'h33);

        for (int i = 0; i < 16; i++) begin
            send(8'h50 + 8'(i), 1'b1, 1'(i % 2));
            chk("full_waits", waits, 0);
        end
        chk("full_cnt_a", cnt_a, m_cnt_a);
        chk("full_cnt_b", cnt_b, m_cnt_b);

        do_reset();
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b1, 1'b0);
        chk("wrap_cnt_a", cnt_a, 1);
        send(8'hB0, 1'b0, 1'b1);
        send(8'hB1, 1'b0, 1'b1);
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_b_valid", b_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cnt_a", cnt_a, 0);
        chk("mid_cnt_b", cnt_b, 0);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'hC0, 1'b1, 1'b0);
        chk("post_a_valid", a_valid, 1);
        chk("post_a_data", a_data, 8'hC0);
        chk("post_b_valid", b_valid, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
